// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for the writeback, decode and register-file stages.
package regfile_pkg;

  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [REG_DATA_W-1:0] reg_word_t;

endpackage

// File: rtl/regfile_wdec.sv
// One-hot write-enable decoder for the register file; entry 0 never receives a write strobe.
module regfile_wdec
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = REG_ADDR_W,
  parameter int unsigned NUM_REGS = 2 ** ADDR_W
) (
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   idx_i,
  output logic [NUM_REGS-1:0] onehot_o
);

  // Decode the index, gated by the strobe so an undriven index cannot leak a write.
  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      onehot_o[i] = we_i && (idx_i == ADDR_W'(i));
    end
    onehot_o[0] = 1'b0;
  end

endmodule

// File: rtl/regfile_rw.sv
// 32 x 32 architectural register file: one write port, two combinational read ports,
// hardwired zero register and optional same-cycle write-to-read bypass.
module regfile_rw
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] wr_en;
  logic                byp_a, byp_b;

  regfile_wdec #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_wdec (
    .we_i     (ctrl_writeEnable),
    .idx_i    (ctrl_writeReg),
    .onehot_o (wr_en)
  );

  // Flop-based storage so the whole array clears asynchronously; entry 0 is never enabled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_en[i]) begin
          regs_q[i] <= data_writeReg;
        end
      end
    end
  end

  // Bypass hits only for a live write to a nonzero index matching the read index.
  always_comb begin
    byp_a = BYPASS && ctrl_writeEnable && (ctrl_writeReg != '0) &&
            (ctrl_readRegA == ctrl_writeReg);
    byp_b = BYPASS && ctrl_writeEnable && (ctrl_writeReg != '0) &&
            (ctrl_readRegB == ctrl_writeReg);
  end

  // Read muxes; index 0 forced to zero so a read of r0 never depends on storage or bypass.
  always_comb begin
    data_readRegA = byp_a ? data_writeReg : regs_q[ctrl_readRegA];
    data_readRegB = byp_b ? data_writeReg : regs_q[ctrl_readRegB];
    if (ctrl_readRegA == '0) data_readRegA = '0;
    if (ctrl_readRegB == '0) data_readRegB = '0;
  end

endmodule

// File: tb/tb_regfile_rw.sv
// Directed plus randomized bench for regfile_rw; one instance with bypass, one without.
module tb_regfile_rw;

  logic        clock;
  logic        reset;
  logic        we;
  logic [4:0]  wr;
  logic [31:0] wd;
  logic [4:0]  ra, rb;
  logic [31:0] a1, b1, a0, b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];

  regfile_rw #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) u_dut_byp (
    .clock            (clock),
    .reset            (reset),
    .ctrl_writeEnable (we),
    .ctrl_writeReg    (wr),
    .data_writeReg    (wd),
    .ctrl_readRegA    (ra),
    .ctrl_readRegB    (rb),
    .data_readRegA    (a1),
    .data_readRegB    (b1)
  );

  regfile_rw #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) u_dut_nobyp (
    .clock            (clock),
    .reset            (reset),
    .ctrl_writeEnable (we),
    .ctrl_writeReg    (wr),
    .data_writeReg    (wd),
    .ctrl_readRegA    (ra),
    .ctrl_readRegB    (rb),
    .data_readRegA    (a0),
    .data_readRegB    (b0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value a read of idx should see right now, from stored contents and the current write.
  function automatic logic [31:0] expect_rd(input logic [4:0] idx, input bit bypass);
    if (idx == 5'd0) return 32'h0;
    if (reset) return 32'h0;
    if (bypass && we === 1'b1 && wr == idx) return wd;
    return model[idx];
  endfunction

  task automatic check_reads(input string tag);
    chk({tag, ":A_byp"},   a1, expect_rd(ra, 1'b1));
    chk({tag, ":B_byp"},   b1, expect_rd(rb, 1'b1));
    chk({tag, ":A_nobyp"}, a0, expect_rd(ra, 1'b0));
    chk({tag, ":B_nobyp"}, b0, expect_rd(rb, 1'b0));
  endtask

  // One clock cycle: drive, check combinational reads, take the edge, update the model.
  task automatic cycle(input string tag, input logic e, input logic [4:0] w,
                       input logic [31:0] d, input logic [4:0] x, input logic [4:0] y);
    we = e; wr = w; wd = d; ra = x; rb = y;
    #1;
    check_reads(tag);
    @(posedge clock);
    if (!reset && e === 1'b1 && w != 5'd0) model[w] = d;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    reset = 1'b1; we = 1'b0; wr = '0; wd = '0; ra = 5'd5; rb = 5'd31;
    @(posedge clock); #1;
    check_reads("reset_state");
    ra = 5'd17; rb = 5'd1; #1;
    check_reads("reset_state2");

    // Write presented in the cycle reset deasserts must land on the first edge.
    reset = 1'b0;
    cycle("rst_rel_wr", 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    cycle("r5_stored", 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    chk("r5_value", a0, 32'hDEADBEEF);

    // Asynchronous reset pulse between edges.
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    chk("async_rst_A_byp", a1, 32'h0);
    chk("async_rst_A_nobyp", a0, 32'h0);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    cycle("after_rst", 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);

    // Basic write/read.
    cycle("wr_r7", 1'b1, 5'd7, 32'h12345678, 5'd8, 5'd1);
    cycle("rd_r7", 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    cycle("rd_r8", 1'b0, 5'd0, 32'h0, 5'd8, 5'd7);

    // Zero register.
    cycle("wr_r0", 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    chk("r0_same_cycle", a1, 32'h0);
    cycle("rd_r0", 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Bypass vs no bypass.
    cycle("setup_r3", 1'b1, 5'd3, 32'h11111111, 5'd1, 5'd2);
    cycle("byp_r3", 1'b1, 5'd3, 32'h22222222, 5'd3, 5'd3);
    cycle("byp_r3_next", 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    chk("r3_nobyp_next", a0, 32'h22222222);

    // Enable gating.
    for (int i = 0; i < 4; i++) cycle("gate_r9", 1'b0, 5'd9, 32'hCAFEF00D, 5'd9, 5'd9);
    chk("r9_still_zero", a0, 32'h0);
    cycle("pulse_r9", 1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd1);
    cycle("rd_r9", 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    chk("r9_written", b0, 32'hCAFEF00D);

    // Back-to-back writes, then dual read.
    cycle("b2b_1", 1'b1, 5'd1, 32'd1, 5'd1, 5'd2);
    cycle("b2b_2", 1'b1, 5'd2, 32'd2, 5'd1, 5'd2);
    cycle("b2b_3", 1'b1, 5'd1, 32'd3, 5'd1, 5'd2);
    cycle("dual_rd", 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
    chk("dual_A", a0, 32'd3);
    chk("dual_B", b0, 32'd2);

    // Sweep all writable indices.
    for (int i = 1; i < 32; i++)
      cycle("sweep_wr", 1'b1, 5'(i), 32'(i) * 32'h01010101, 5'(i), 5'(31 - i));
    for (int i = 0; i < 32; i++) begin
      cycle("sweep_rd", 1'b0, 5'd0, 32'h0, 5'(i), 5'(i));
      chk("sweep_exact", b0, 32'(i) * 32'h01010101);
    end

    // Randomized traffic, reads often aimed at the write index to exercise bypass.
    for (int n = 0; n < 400; n++) begin
      logic        e;
      logic [4:0]  w, x, y;
      logic [31:0] d;
      e = 1'($urandom_range(0, 1));
      w = 5'($urandom);
      d = $urandom;
      x = ($urandom_range(0, 2) == 0) ? w : 5'($urandom);
      y = ($urandom_range(0, 2) == 0) ? w : 5'($urandom);
      if (!e && $urandom_range(0, 1) == 1) begin
        w = 'x;
        d = 'x;
      end
      cycle("random", e, w, d, x, y);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
